// File: rtl/sst_map_sequencer.sv
// Save-state bus initiator: streams mapper registers out on save and writes a
// checked byte stream back into the mapper on restore.
module sst_map_sequencer #(
   parameter int NREGS    = 127,
   parameter int IDX_ADDR = 127,
   parameter int READ_LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_m3,
   input  logic       start,
   input  logic       mode,
   input  logic [7:0] map_idx,
   output logic       sst_act,
   output logic       sst_we_reg,
   output logic [7:0] sst_addr,
   output logic [7:0] sst_dato,
   input  logic [7:0] sst_di,
   output logic [7:0] so_data,
   output logic       so_valid,
   input  logic       so_ready,
   input  logic [7:0] si_data,
   input  logic       si_valid,
   output logic       si_ready,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [7:0] LAST_ADDR = 8'(NREGS - 1);
   localparam logic [7:0] IDX_A     = 8'(IDX_ADDR);
   localparam logic [2:0] LAT_M1    = 3'(READ_LAT - 1);

   typedef enum logic [2:0] {
      IDLE, RD_SET, RD_WAIT, SO_PUSH, SI_PULL, WR_HOLD, FIN
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] addr_reg, addr_next;
   logic [7:0] dato_reg, dato_next;
   logic [7:0] data_reg, data_next;
   logic [2:0] cnt_reg, cnt_next;
   logic       mode_reg, mode_next;
   logic       idx_phase_reg, idx_phase_next;
   logic       skip_reg, skip_next;
   logic       err_reg, err_next;
   logic [7:0] addr_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         addr_reg      <= 8'd0;
         dato_reg      <= 8'd0;
         data_reg      <= 8'd0;
         cnt_reg       <= 3'd0;
         mode_reg      <= 1'b0;
         idx_phase_reg <= 1'b0;
         skip_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         dato_reg      <= dato_next;
         data_reg      <= data_next;
         cnt_reg       <= cnt_next;
         mode_reg      <= mode_next;
         idx_phase_reg <= idx_phase_next;
         skip_reg      <= skip_next;
         err_reg       <= err_next;
      end
   end

   // The index byte is read from IDX_ADDR; the register walk then starts at 0.
   assign addr_step = idx_phase_reg ? 8'd0 : addr_reg + 8'd1;

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      dato_next      = dato_reg;
      data_next      = data_reg;
      cnt_next       = cnt_reg;
      mode_next      = mode_reg;
      idx_phase_next = idx_phase_reg;
      skip_next      = skip_reg;
      err_next       = err_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               err_next       = 1'b0;
               mode_next      = mode;
               addr_next      = IDX_A;
               idx_phase_next = 1'b1;
               state_next     = RD_SET;
            end
         end
         RD_SET: begin
            cnt_next   = LAT_M1;
            state_next = RD_WAIT;
         end
         RD_WAIT: begin
            if (cnt_reg == 3'd0) begin
               data_next = sst_di;
               if (!mode_reg) begin
                  state_next = SO_PUSH;
               end else if (sst_di != map_idx) begin
                  err_next   = 1'b1;
                  state_next = IDLE;
               end else begin
                  skip_next  = 1'b1;
                  state_next = SI_PULL;
               end
            end else begin
               cnt_next = cnt_reg - 3'd1;
            end
         end
         SO_PUSH: begin
            if (so_ready) begin
               if (!idx_phase_reg && addr_reg == LAST_ADDR) begin
                  state_next = FIN;
               end else begin
                  addr_next      = addr_step;
                  idx_phase_next = 1'b0;
                  state_next     = RD_SET;
               end
            end
         end
         SI_PULL: begin
            if (si_valid) begin
               if (skip_reg) begin
                  skip_next = 1'b0;
               end else begin
                  dato_next      = si_data;
                  addr_next      = addr_step;
                  idx_phase_next = 1'b0;
                  state_next     = WR_HOLD;
               end
            end
         end
         WR_HOLD: begin
            // Only an M3 edge commits, so stay here until one arrives.
            if (cpu_m3) begin
               state_next = (addr_reg == LAST_ADDR) ? FIN : SI_PULL;
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign sst_act    = (state_reg != IDLE) && (state_reg != FIN);
   assign busy       = sst_act;
   assign sst_we_reg = (state_reg == WR_HOLD);
   assign sst_addr   = addr_reg;
   assign sst_dato   = dato_reg;
   assign so_data    = data_reg;
   assign so_valid   = (state_reg == SO_PUSH);
   assign si_ready   = (state_reg == SI_PULL);
   assign done       = (state_reg == FIN);
   assign err        = err_reg;

endmodule

// File: tb/tb_sst_map_sequencer.sv
// Directed bench for sst_map_sequencer: a small mapper model with a two-cycle
// read pipeline, stream source/sink and commit tracking.
module tb_sst_map_sequencer;

   logic       clk = 1'b0;
   logic       rst, cpu_m3, start, mode;
   logic [7:0] map_idx;
   logic       sst_act, sst_we_reg;
   logic [7:0] sst_addr, sst_dato, sst_di;
   logic [7:0] so_data;
   logic       so_valid, so_ready;
   logic [7:0] si_data;
   logic       si_valid, si_ready;
   logic       busy, done, err;

   sst_map_sequencer #(.NREGS(127), .IDX_ADDR(127), .READ_LAT(2)) dut (
      .clk(clk), .rst(rst), .cpu_m3(cpu_m3), .start(start), .mode(mode),
      .map_idx(map_idx), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
      .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(sst_di),
      .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
      .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Stimulus pattern controls (written only by the main initial block)
   logic rdy_mode = 1'b0;
   logic m3_mode = 1'b0;
   logic si_en = 1'b0;
   logic stall_en = 1'b0;
   logic mon_clr = 1'b0;

   // Monitor state (written only by the posedge monitor)
   logic [7:0] mem [0:126];
   logic [7:0] a_d1, a_d2;
   logic [7:0] so_q [0:255];
   int so_cnt, done_cnt, we_cnt, si_rdy_cnt, commits, bad_wr, stab, after_commit;
   int si_ptr, exp_wr;
   logic commit40, prev_commit, prev_stall;
   logic [7:0] prev_data;

   // Negedge input driver
   int cyc = 0;
   logic stalled = 1'b0;
   always @(negedge clk) begin
      cyc++;
      so_ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
      if (!stall_en) stalled = 1'b0;
      else if (sst_we_reg && sst_addr == 8'd40) stalled = 1'b1;
      cpu_m3 = stalled ? 1'b0 : (m3_mode ? (cyc % 8 == 0) : 1'b1);
      si_valid = si_en;
      si_data = (si_ptr == 0) ? 8'h42 : 8'(si_ptr - 1);
   end

   // Mapper read data is valid two cycles after the address settles.
   assign sst_di = (a_d2 == 8'd127) ? 8'h42 : mem[a_d2[6:0]];

   always @(posedge clk) begin
      a_d1 <= sst_addr;
      a_d2 <= a_d1;
      if (mon_clr) begin
         for (int n = 0; n < 127; n++) mem[n] <= 8'(n) ^ 8'h5A;
         so_cnt <= 0; done_cnt <= 0; we_cnt <= 0; si_rdy_cnt <= 0;
         commits <= 0; bad_wr <= 0; stab <= 0; after_commit <= 0;
         si_ptr <= 0; exp_wr <= 0; commit40 <= 1'b0;
         prev_commit <= 1'b0; prev_stall <= 1'b0; prev_data <= 8'h00;
      end else begin
         if (so_valid && so_ready) begin
            so_q[so_cnt[7:0]] <= so_data;
            so_cnt <= so_cnt + 1;
         end
         if (prev_stall && (!so_valid || so_data != prev_data)) stab <= stab + 1;
         prev_stall <= so_valid && !so_ready;
         prev_data <= so_data;
         if (done) done_cnt <= done_cnt + 1;
         if (sst_we_reg) we_cnt <= we_cnt + 1;
         if (si_ready) si_rdy_cnt <= si_rdy_cnt + 1;
         if (si_valid && si_ready) si_ptr <= si_ptr + 1;
         if (prev_commit && sst_we_reg) after_commit <= after_commit + 1;
         prev_commit <= sst_we_reg && cpu_m3;
         if (sst_we_reg && cpu_m3) begin
            mem[sst_addr[6:0]] <= sst_dato;
            commits <= commits + 1;
            if (sst_addr != 8'(exp_wr)) bad_wr <= bad_wr + 1;
            exp_wr <= exp_wr + 1;
            if (sst_addr == 8'd40) commit40 <= 1'b1;
         end
      end
   end

   task automatic clear_mon();
      @(negedge clk) mon_clr = 1'b1;
      @(negedge clk) mon_clr = 1'b0;
   endtask

   task automatic do_start(input logic m);
      @(negedge clk) begin start = 1'b1; mode = m; end
      @(negedge clk) start = 1'b0;
   endtask

   task automatic run_wait(input string tag);
      int n = 0;
      while (!(done || err) && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_no_timeout"}, 32'(n < 6000), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_save_bytes(input string tag);
      check({tag, "_bytes"}, 32'(so_cnt), 32'd128);
      for (int k = 0; k < 128; k++)
         check($sformatf("%s_b%0d", tag, k), 32'(so_q[k]),
               (k == 0) ? 32'h42 : 32'(8'(k - 1) ^ 8'h5A));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; map_idx = 8'h42;
      repeat (2) @(negedge clk);
      mon_clr = 1'b1;
      repeat (2) @(negedge clk);
      mon_clr = 1'b0;
      check("rst_act", 32'(sst_act), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_we", 32'(sst_we_reg), 0);
      check("rst_addr", 32'(sst_addr), 0);
      check("rst_dato", 32'(sst_dato), 0);
      check("rst_so_valid", 32'(so_valid), 0);
      check("rst_si_ready", 32'(si_ready), 0);
      check("rst_done_err", 32'({done, err}), 0);
      rst = 1'b0;

      // Save, ready tied high
      clear_mon();
      do_start(1'b0);
      check("save1_act", 32'(sst_act), 1);
      check("save1_busy", 32'(busy), 1);
      run_wait("save1");
      check_save_bytes("save1");
      check("save1_done", 32'(done_cnt), 1);
      check("save1_we", 32'(we_cnt), 0);
      check("save1_act_end", 32'(sst_act), 0);

      // Save, ready 1-in-3, with a stray start mid-operation
      rdy_mode = 1'b1;
      clear_mon();
      do_start(1'b0);
      repeat (50) @(negedge clk);
      do_start(1'b1);
      run_wait("save2");
      check_save_bytes("save2");
      check("save2_stable", 32'(stab), 0);
      check("save2_done", 32'(done_cnt), 1);
      check("save2_we", 32'(we_cnt), 0);
      rdy_mode = 1'b0;

      // Restore, matching index, M3 high 1-in-8
      m3_mode = 1'b1;
      clear_mon();
      si_en = 1'b1;
      map_idx = 8'h42;
      do_start(1'b1);
      run_wait("rest1");
      check("rest1_commits", 32'(commits), 127);
      check("rest1_order", 32'(bad_wr), 0);
      check("rest1_we_after", 32'(after_commit), 0);
      check("rest1_done", 32'(done_cnt), 1);
      check("rest1_err", 32'(err), 0);
      for (int n = 0; n < 127; n++)
         check($sformatf("rest1_r%0d", n), 32'(mem[n]), 32'(n));

      // Restore, mismatching index
      clear_mon();
      map_idx = 8'h43;
      do_start(1'b1);
      run_wait("rest2");
      check("rest2_err", 32'(err), 1);
      check("rest2_commits", 32'(commits), 0);
      check("rest2_done", 32'(done_cnt), 0);
      check("rest2_si_ready", 32'(si_rdy_cnt), 0);
      check("rest2_act", 32'(sst_act), 0);
      si_en = 1'b0;
      clear_mon();
      do_start(1'b0);
      check("rest2_err_clr", 32'(err), 0);
      run_wait("save3");
      check("save3_bytes", 32'(so_cnt), 128);
      check("save3_done", 32'(done_cnt), 1);

      // Reset while holding the write at address 40
      m3_mode = 1'b0;
      clear_mon();
      si_en = 1'b1;
      map_idx = 8'h42;
      stall_en = 1'b1;
      do_start(1'b1);
      begin
         int n = 0;
         while (!stalled && n < 3000) begin
            @(negedge clk);
            n++;
         end
         check("rst40_reached", 32'(stalled), 1);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst40_we", 32'(sst_we_reg), 0);
      check("rst40_act", 32'(sst_act), 0);
      check("rst40_addr", 32'(sst_addr), 0);
      check("rst40_si_ready", 32'(si_ready), 0);
      rst = 1'b0;
      stall_en = 1'b0;
      si_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst40_commit40", 32'(commit40), 0);
      check("rst40_commits", 32'(commits), 40);
      check("rst40_done", 32'(done_cnt), 0);
      clear_mon();
      do_start(1'b0);
      run_wait("save4");
      check_save_bytes("save4");
      check("save4_done", 32'(done_cnt), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
